// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter that sequences single-word accesses onto the shared
// port B of the IRAM/DRAM SRAMs, accounting for their 1-cycle registered read latency.
module wb_ram_arbiter #(
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter int unsigned RAM_DATA_WIDTH = 32,
  parameter int unsigned DRAM_SEL_BIT   = 14
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [31:0]               m0_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] m0_wdata_i,
  output logic [RAM_DATA_WIDTH-1:0] m0_rdata_o,
  output logic                      m0_ack_o,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [31:0]               m1_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] m1_wdata_i,
  output logic [RAM_DATA_WIDTH-1:0] m1_rdata_o,
  output logic                      m1_ack_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] ram_wdata_o,
  output logic                      iram_we_o,
  output logic                      dram_we_o,
  input  logic [RAM_DATA_WIDTH-1:0] iram_rdata_i,
  input  logic [RAM_DATA_WIDTH-1:0] dram_rdata_i,
  output logic [1:0]                grant_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StAck} state_e;

  state_e                    state_q;
  logic                      last_grant_q;
  logic                      owner_q;
  logic                      we_q;
  logic                      sel_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_DATA_WIDTH-1:0] wdata_q;
  logic [RAM_DATA_WIDTH-1:0] rdata_q;

  logic                      req0;
  logic                      req1;
  logic                      win1;
  logic                      win_we;
  logic [31:0]               win_addr;
  logic [RAM_DATA_WIDTH-1:0] win_wdata;
  logic                      ack_phase;

  // Only the word-address and RAM-select bits matter; everything else aliases.
  logic                      unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr_i, m1_addr_i};

  always_comb begin
    req0 = m0_cyc_i & m0_stb_i;
    req1 = m1_cyc_i & m1_stb_i;
    // On a tie the master that did not win last time goes first.
    win1      = req1 & (~req0 | ~last_grant_q);
    win_we    = win1 ? m1_we_i    : m0_we_i;
    win_addr  = win1 ? m1_addr_i  : m0_addr_i;
    win_wdata = win1 ? m1_wdata_i : m0_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      grant_o      <= 2'b00;
      iram_we_o    <= 1'b0;
      dram_we_o    <= 1'b0;
    end else begin
      iram_we_o <= 1'b0;
      dram_we_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            state_q      <= StAccess;
            owner_q      <= win1;
            last_grant_q <= win1;
            grant_o      <= win1 ? 2'b10 : 2'b01;
            we_q         <= win_we;
            sel_q        <= win_addr[DRAM_SEL_BIT];
            addr_q       <= win_addr[RAM_ADDR_WIDTH+1:2];
            wdata_q      <= win_wdata;
            // Strobe is registered so it lines up exactly with the ACCESS cycle.
            iram_we_o    <= win_we & ~win_addr[DRAM_SEL_BIT];
            dram_we_o    <= win_we & win_addr[DRAM_SEL_BIT];
          end
        end
        StAccess: state_q <= we_q ? StAck : StRdWait;
        StRdWait: begin
          rdata_q <= sel_q ? dram_rdata_i : iram_rdata_i;
          state_q <= StAck;
        end
        StAck: begin
          state_q <= StIdle;
          grant_o <= 2'b00;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_phase   = (state_q == StAck);
  assign m0_ack_o    = ack_phase & ~owner_q & m0_cyc_i;
  assign m1_ack_o    = ack_phase & owner_q & m1_cyc_i;
  assign m0_rdata_o  = (m0_ack_o && !we_q) ? rdata_q : '0;
  assign m1_rdata_o  = (m1_ack_o && !we_q) ? rdata_q : '0;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level timeline model.
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, iram_q, dram_q;
  logic        m0_ack, m1_ack, iram_we, dram_we;
  logic [11:0] ram_addr;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .iram_we_o(iram_we), .dram_we_o(dram_we),
    .iram_rdata_i(iram_q), .dram_rdata_i(dram_q), .grant_o(grant)
  );

  function automatic logic [31:0] init_word(input int sel, input int idx);
    return 32'hA500_0000 ^ (32'(sel) << 20) ^ (32'(idx) * 32'h0000_9E37);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM port-B models: synchronous write, registered read.
  logic [31:0] iram_mem [4096];
  logic [31:0] dram_mem [4096];
  bit          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) begin
        iram_mem[i] <= init_word(0, i);
        dram_mem[i] <= init_word(1, i);
      end
      mem_ready <= 1'b1;
    end else begin
      if (iram_we) iram_mem[ram_addr] <= ram_wdata;
      if (dram_we) dram_mem[ram_addr] <= ram_wdata;
      iram_q <= iram_mem[ram_addr];
      dram_q <= dram_mem[ram_addr];
    end
  end

  // Timeline model: a transaction granted from an idle cycle s occupies cycles s+1..s+len,
  // len = 2 for writes and 3 for reads; the write lands in cycle s+1, the ack is in s+len.
  logic [31:0] mm_i [4096];
  logic [31:0] mm_d [4096];
  bit          model_ready = 1'b0;
  bit          m_busy = 1'b0, m_last = 1'b1, m_after_rst = 1'b0, idle_now;
  int          m_off, m_len, m_owner;
  logic        m_we, m_sel, e_acc, e_a0, e_a1, r0, r1;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rd;
  logic [1:0]  e_g;

  always @(negedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 4096; i++) begin
        mm_i[i] = init_word(0, i);
        mm_d[i] = init_word(1, i);
      end
      model_ready = 1'b1;
    end
    idle_now = !m_busy;
    if (m_busy) m_off++;
    e_g   = !m_busy ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
    e_acc = m_busy && m_off == 1;
    e_a0  = m_busy && m_off == m_len && m_owner == 0 && m0_cyc;
    e_a1  = m_busy && m_off == m_len && m_owner == 1 && m1_cyc;
    chk("grant", 64'(grant), 64'(e_g));
    chk("m0_ack", 64'(m0_ack), 64'(e_a0));
    chk("m1_ack", 64'(m1_ack), 64'(e_a1));
    chk("m0_rdata", 64'(m0_rdata), 64'((e_a0 && !m_we) ? m_rd : 32'h0));
    chk("m1_rdata", 64'(m1_rdata), 64'((e_a1 && !m_we) ? m_rd : 32'h0));
    chk("iram_we", 64'(iram_we), 64'(e_acc && m_we && !m_sel));
    chk("dram_we", 64'(dram_we), 64'(e_acc && m_we && m_sel));
    if (e_acc) chk("ram_addr", 64'(ram_addr), 64'(m_addr));
    if (e_acc && m_we) chk("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
    if (m_after_rst) begin
      chk("rst_ram_addr", 64'(ram_addr), 64'h0);
      chk("rst_ram_wdata", 64'(ram_wdata), 64'h0);
    end
    if (e_acc && m_we) begin
      if (m_sel) mm_d[m_addr] = m_wdata;
      else       mm_i[m_addr] = m_wdata;
    end
    if (m_busy && m_off == m_len) m_busy = 1'b0;
    m_after_rst = 1'b0;
    r0 = m0_cyc && m0_stb;
    r1 = m1_cyc && m1_stb;
    if (rst) begin
      m_busy      = 1'b0;
      m_last      = 1'b1;
      m_after_rst = 1'b1;
    end else if (idle_now && (r0 || r1)) begin
      if (r0 && r1) m_owner = m_last ? 0 : 1;
      else          m_owner = r1 ? 1 : 0;
      m_last  = (m_owner == 1);
      m_we    = (m_owner == 1) ? m1_we : m0_we;
      m_addr  = (m_owner == 1) ? m1_addr[13:2] : m0_addr[13:2];
      m_sel   = (m_owner == 1) ? m1_addr[14] : m0_addr[14];
      m_wdata = (m_owner == 1) ? m1_wdata : m0_wdata;
      m_rd    = m_sel ? mm_d[m_addr] : mm_i[m_addr];
      m_len   = m_we ? 2 : 3;
      m_off   = 0;
      m_busy  = 1'b1;
    end
  end

  task automatic set_req(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
    else        begin m1_cyc = 1'b0; m1_stb = 1'b0; end
  endtask

  // Called at posedge+1 of the cycle in which master m's request is first sampled (cycle 0).
  task automatic wait_ack(input int m, output int lat, output logic [31:0] rd, output int ndwe,
                          output int niwe, output logic [1:0] g1);
    lat = -1; rd = '0; ndwe = 0; niwe = 0; g1 = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dram_we) ndwe++;
      if (iram_we) niwe++;
      if (k == 1) g1 = grant;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        lat = k;
        rd  = (m == 1) ? m1_rdata : m0_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drop(m);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[13:6] = '0;
    return a;
  endfunction

  int          lat, ndwe, niwe, other_ack;
  logic [31:0] rd;
  logic [1:0]  g1, g;
  bit          found;
  bit          act [2];
  bit          acked [2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    // Reset held with m0 requesting a DRAM write.
    set_req(0, 1'b1, 32'h0000_4010, 32'hDEAD_BEEF);
    repeat (2) begin
      @(negedge clk);
      chk("rst_acks", 64'({m0_ack, m1_ack}), 64'h0);
      chk("rst_we", 64'({iram_we, dram_we}), 64'h0);
      chk("rst_grant", 64'(grant), 64'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wait_ack(0, lat, rd, ndwe, niwe, g1);
    chk("t1_first_grant", 64'(g1), 64'h1);
    chk("t2_wr_lat", 64'(lat), 64'd2);
    chk("t2_dram_we_cycles", 64'(ndwe), 64'd1);
    chk("t2_dram_word4", 64'(dram_mem[4]), 64'hDEAD_BEEF);
    chk("t2_iram_we_wr", 64'(niwe), 64'd0);
    set_req(0, 1'b0, 32'h0000_4010, 32'h0);
    wait_ack(0, lat, rd, ndwe, niwe, g1);
    chk("t2_rd_lat", 64'(lat), 64'd3);
    chk("t2_rd_data", 64'(rd), 64'hDEAD_BEEF);
    chk("t2_iram_we_rd", 64'(niwe), 64'd0);

    set_req(1, 1'b1, 32'h0000_0008, 32'h1234_5678);
    wait_ack(1, lat, rd, ndwe, niwe, g1);
    chk("t3_wr_lat", 64'(lat), 64'd2);
    chk("t3_iram_word2", 64'(iram_mem[2]), 64'h1234_5678);
    set_req(1, 1'b0, 32'h0000_4008, 32'h0);
    wait_ack(1, lat, rd, ndwe, niwe, g1);
    chk("t3_dram_rd_ack", 64'(lat >= 0), 64'h1);
    chk("t3_no_alias", 64'(rd == 32'h1234_5678), 64'h0);

    // Both masters hold read requests; ownership must alternate starting with m0.
    set_req(0, 1'b0, 32'h0000_4010, 32'h0);
    set_req(1, 1'b0, 32'h0000_0008, 32'h0);
    for (int t = 0; t < 6; t++) begin
      g = 2'b00;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1; @(negedge clk);
        g = grant;
        if (g != 2'b00) break;
      end
      chk("t4_grant", 64'(g), (t % 2 == 0) ? 64'h1 : 64'h2);
      found = 1'b0; other_ack = 0; rd = '0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1; @(negedge clk);
        if ((t % 2 == 0) ? m1_ack : m0_ack) other_ack++;
        if ((t % 2 == 0) ? m0_ack : m1_ack) begin
          found = 1'b1;
          rd = (t % 2 == 0) ? m0_rdata : m1_rdata;
          break;
        end
      end
      chk("t4_own_ack", 64'(found), 64'h1);
      chk("t4_other_ack", 64'(other_ack), 64'd0);
      chk("t4_rdata", 64'(rd), (t % 2 == 0) ? 64'hDEAD_BEEF : 64'h1234_5678);
    end
    @(posedge clk); #1;
    drop(0); drop(1);

    // m1 read aborted during RDWAIT while m0 waits.
    set_req(1, 1'b0, 32'h0000_4010, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drop(1);
    set_req(0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t5_rdwait_m1_ack", 64'(m1_ack), 64'h0);
    @(posedge clk); #1; @(negedge clk);
    chk("t5_ack_m1_ack", 64'(m1_ack), 64'h0);
    chk("t5_ack_grant", 64'(grant), 64'h2);
    @(posedge clk); #1; @(negedge clk);
    chk("t5_idle_grant", 64'(grant), 64'h0);
    @(posedge clk); #1; @(negedge clk);
    chk("t5_m0_granted", 64'(grant), 64'h1);
    @(posedge clk); #1;
    wait_ack(0, lat, rd, ndwe, niwe, g1);
    chk("t5_m0_ack", 64'(lat >= 0), 64'h1);
    chk("t5_m0_wrote", 64'(iram_mem[64]), 64'hCAFE_F00D);

    // Reset during the ACCESS cycle of an m0 write.
    set_req(0, 1'b1, 32'h0000_4020, 32'h1111_2222);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drop(0);
    @(negedge clk);
    chk("t6_grant", 64'(grant), 64'h0);
    chk("t6_we", 64'({iram_we, dram_we}), 64'h0);
    chk("t6_ram_addr", 64'(ram_addr), 64'h0);
    other_ack = 0;
    for (int k = 0; k < 4; k++) begin
      if (m0_ack || m1_ack) other_ack++;
      @(posedge clk); #1; @(negedge clk);
    end
    chk("t6_no_ack", 64'(other_ack), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic, checked by the model every cycle.
    act[0] = 0; act[1] = 0; acked[0] = 0; acked[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        if (act[m] && (acked[m] || $urandom_range(0, 39) == 0)) begin
          drop(m);
          act[m] = 1'b0;
        end else if (!act[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(m, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
            act[m] = 1'b1;
          end else if (m == 0) begin
            m0_cyc = ($urandom_range(0, 7) == 0); m0_stb = 1'b0;
          end else begin
            m1_cyc = ($urandom_range(0, 7) == 0); m1_stb = 1'b0;
          end
        end
      end
      @(negedge clk);
      acked[0] = m0_ack;
      acked[1] = m1_ack;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drop(0); drop(1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
